pwm_duty_sched: RTL and testbench
=================================

PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

Interface
REQ-001 SHALL have parameter DEB_CYC, default 1000000, meaning the number of cycles a key must be stable to register (20 ms at 50 MHz).
REQ-002 SHALL have parameter RAMP_DIV, default 2500000, meaning cycles between ramp steps.
REQ-003 SHALL have parameter STEP, default 5, meaning the duty increment per key press or ramp tick (1..100).
REQ-004 SHALL have port CLK  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port PUSH  in  3  raw push keys, active-low, asynchronous: [0] up, [1] down, [2] mode toggle.
REQ-007 SHALL have port UPD_ACK  in  1  PWM core accepts DUTY (single-cycle pulse).
REQ-008 SHALL have port DUTY  out  7  committed duty request to the PWM core, 0..100 percent.
REQ-009 SHALL have port UPD_REQ  out  1  update request to the PWM core.
REQ-010 SHALL have port MODE  out  1  0 = manual, 1 = ramp.
REQ-011 SHALL have port BCD_HUN  out  1  hundreds digit of the target duty.
REQ-012 SHALL have port BCD_TEN  out  4  tens digit of the target duty.
REQ-013 SHALL have port BCD_ONE  out  4  ones digit of the target duty.

Function
REQ-014 SHALL pass each PUSH bit through a 2-flop synchronizer before any use.
REQ-015 SHALL give each key its own debouncer: the counter clears on any change of the synced level; the level is accepted after DEB_CYC equal samples; an accepted 1->0 transition produces a one-cycle press event.
REQ-016 SHALL hold the key's press event to the single cycle of the accepted 1->0 transition, with no event on release and no auto-repeat.
REQ-017 SHALL, in manual mode, make an up press set target = min(target+STEP, 100) and a down press set target = max(target-STEP, 0), using 8-bit intermediate arithmetic with no wrap.
REQ-018 SHALL ignore both presses when up and down events occur in the same cycle.
REQ-019 SHALL toggle MODE on a mode event, taking precedence over an up/down event in the same cycle.
REQ-020 SHALL, on entering ramp mode, clear the ramp prescaler and set direction to up, or to down when target = 100.
REQ-021 SHALL, in ramp mode, ignore up/down events; on each prescaler terminal count (every RAMP_DIV cycles), step target by STEP in the current direction.
REQ-022 SHALL, in ramp mode, clamp the target at 100 or 0 and reverse direction in the same cycle, producing a triangle wave.
REQ-023 SHALL, on leaving ramp mode, hold the current target.
REQ-024 SHALL use a two-state handshake FSM, IDLE and PEND.
REQ-025 SHALL transition IDLE->PEND when target != DUTY, loading the DUTY register with target and asserting UPD_REQ in the next cycle.
REQ-026 SHALL, in PEND, keep DUTY and UPD_REQ stable until UPD_ACK; target may keep changing meanwhile.
REQ-027 SHALL, in PEND, on UPD_ACK, deassert UPD_REQ and return to IDLE; a target that differs from DUTY starts a new request on the following cycle.
REQ-028 SHALL ignore UPD_ACK when in IDLE.
REQ-029 SHALL derive the BCD outputs combinationally from target: 100 gives 1/0/0.
REQ-030 SHALL keep the PUSH to UPD_REQ latency at no more than 2 + DEB_CYC + 2 cycles.

Reset
REQ-031 SHALL, while RST is high at a clock edge, set DUTY = 0, target = 0, UPD_REQ = 0, MODE = 0, FSM = IDLE, direction = up, all debouncers to accepted level 1 with counters 0, and the prescaler to 0.
REQ-032 SHALL abandon any pending request on reset mid-handshake, with no UPD_REQ in the cycle after reset.
REQ-033 SHALL produce no output changes after reset until a press event or ramp tick occurs.

Verification (DEB_CYC=4, RAMP_DIV=8, STEP=5)
REQ-034 SHALL check: PUSH[0] low for 3 cycles then high -> no event, DUTY stays 0, UPD_REQ stays 0.
REQ-035 SHALL check: PUSH[0] held low for 20 cycles -> exactly one event, UPD_REQ rises with DUTY = 5, BCD 0/0/5; UPD_ACK -> UPD_REQ = 0 on the next cycle.
REQ-036 SHALL check: 21 up presses -> target saturates at 100, BCD 1/0/0; 21 down presses -> target 0, no underflow.
REQ-037 SHALL check: two up presses while UPD_ACK is withheld -> DUTY stays 5 while PEND; after ACK, a second request with DUTY = 10.
REQ-038 SHALL check: mode press at target 95 -> ramp gives 100 after 8 cycles, then 95, 90, ...; a second mode press freezes the target.
REQ-039 SHALL check: RST asserted while UPD_REQ = 1 -> next cycle UPD_REQ = 0, DUTY = 0, MODE = 0.

Source files
------------

// File: rtl/pwm_duty_sched.sv
// Debounced up/down/mode keys drive a 0..100 duty target (manual or triangle ramp);
// the target is committed to the PWM core through a REQ/ACK handshake, with BCD of the target.
module pwm_duty_sched #(
    parameter int DEB_CYC  = 1000000,
    parameter int RAMP_DIV = 2500000,
    parameter int STEP     = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] PUSH,
    input  logic       UPD_ACK,
    output logic [6:0] DUTY,
    output logic       UPD_REQ,
    output logic       MODE,
    output logic       BCD_HUN,
    output logic [3:0] BCD_TEN,
    output logic [3:0] BCD_ONE
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [PW-1:0] RAMP_LAST = PW'(RAMP_DIV - 1);
    localparam logic [7:0]    STEP8     = 8'(STEP);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    logic [2:0]    r_sync1, r_sync2;
    logic [2:0]    r_deb_lvl;
    logic [DW-1:0] r_deb_cnt [3];
    logic [2:0]    w_evt;
    logic [6:0]    r_target;
    logic          r_mode;
    logic          r_dir_dn;
    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [6:0]    r_duty;
    logic          r_upd_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= PUSH;
            r_sync2 <= r_sync1;
        end
    end

    // Counter runs only while the synced level differs from the accepted one
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_deb_lvl <= 3'b111;
            for (int k = 0; k < 3; k++) r_deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_deb_lvl[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DEB_LAST) begin
                    r_deb_lvl[k] <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_evt = '0;
        for (int k = 0; k < 3; k++)
            w_evt[k] = (r_sync2[k] != r_deb_lvl[k]) && (r_deb_cnt[k] == DEB_LAST) && !r_sync2[k];
    end

    logic [7:0] w_up_sum;
    logic       w_up_hit, w_dn_hit;
    logic [6:0] w_up_sat, w_dn_sat;

    always_comb begin
        w_up_sum = {1'b0, r_target} + STEP8;
        w_up_hit = (w_up_sum >= 8'd100);
        w_dn_hit = ({1'b0, r_target} <= STEP8);
        w_up_sat = w_up_hit ? 7'd100 : w_up_sum[6:0];
        w_dn_sat = w_dn_hit ? 7'd0 : (r_target - STEP8[6:0]);
    end

    // A mode event wins over everything else in its cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_target <= '0;
            r_mode   <= 1'b0;
            r_dir_dn <= 1'b0;
            r_presc  <= '0;
        end else if (w_evt[2]) begin
            r_mode <= ~r_mode;
            if (!r_mode) begin
                r_presc  <= '0;
                r_dir_dn <= (r_target == 7'd100);
            end
        end else if (!r_mode) begin
            if (w_evt[0] && !w_evt[1])
                r_target <= w_up_sat;
            else if (w_evt[1] && !w_evt[0])
                r_target <= w_dn_sat;
        end else if (r_presc == RAMP_LAST) begin
            r_presc <= '0;
            if (!r_dir_dn) begin
                r_target <= w_up_sat;
                if (w_up_hit) r_dir_dn <= 1'b1;
            end else begin
                r_target <= w_dn_sat;
                if (w_dn_hit) r_dir_dn <= 1'b0;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_duty    <= '0;
            r_upd_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (r_target != r_duty) begin
                    r_duty    <= r_target;
                    r_upd_req <= 1'b1;
                    r_state   <= S_PEND;
                end
                S_PEND: if (UPD_ACK) begin
                    r_upd_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [6:0] w_rem;
    logic [3:0] w_ten, w_one;

    always_comb begin
        w_rem = (r_target >= 7'd100) ? (r_target - 7'd100) : r_target;
        w_ten = '0;
        w_one = w_rem[3:0];
        for (int i = 1; i < 10; i++) begin
            if (w_rem >= 7'(i * 10)) begin
                w_ten = 4'(i);
                w_one = 4'(w_rem - 7'(i * 10));
            end
        end
    end

    assign DUTY    = r_duty;
    assign UPD_REQ = r_upd_req;
    assign MODE    = r_mode;
    assign BCD_HUN = (r_target >= 7'd100);
    assign BCD_TEN = w_ten;
    assign BCD_ONE = w_one;
endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: key presses as transactions against a percentage-level model.
module tb_pwm_duty_sched;
    localparam int DEB  = 4;
    localparam int RDIV = 8;
    localparam int STP  = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] PUSH = 3'b111;
    logic       UPD_ACK;
    logic [6:0] DUTY;
    logic       UPD_REQ, MODE, BCD_HUN;
    logic [3:0] BCD_TEN, BCD_ONE;

    logic ack_en = 1'b0, auto_ack = 1'b0, man_ack = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   mdl_t = 0, mdl_dir = 1;

    assign UPD_ACK = ack_en ? auto_ack : man_ack;

    pwm_duty_sched #(.DEB_CYC(DEB), .RAMP_DIV(RDIV), .STEP(STP)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .UPD_ACK(UPD_ACK), .DUTY(DUTY),
        .UPD_REQ(UPD_REQ), .MODE(MODE), .BCD_HUN(BCD_HUN), .BCD_TEN(BCD_TEN), .BCD_ONE(BCD_ONE)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        #1;
        auto_ack = ack_en && UPD_REQ && !auto_ack;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bcd_of(input int t);
        return {23'd0, (t == 100), 4'((t % 100) / 10), 4'(t % 10)};
    endfunction

    function automatic logic [31:0] bcd_obs();
        return {23'd0, BCD_HUN, BCD_TEN, BCD_ONE};
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_bcd"}, bcd_obs(), bcd_of(mdl_t));
        chk({tag, "_duty"}, 32'(DUTY), 32'(mdl_t));
    endtask

    task automatic mdl_press(input bit up, input bit dn);
        if (up && !dn)
            mdl_t = (mdl_t + STP > 100) ? 100 : mdl_t + STP;
        else if (dn && !up)
            mdl_t = (mdl_t - STP < 0) ? 0 : mdl_t - STP;
    endtask

    task automatic mdl_ramp_step;
        mdl_t += mdl_dir * STP;
        if (mdl_t >= 100) begin
            mdl_t = 100;
            mdl_dir = -1;
        end else if (mdl_t <= 0) begin
            mdl_t = 0;
            mdl_dir = 1;
        end
    endtask

    // Hold the selected keys low for len cycles, then release and let it settle
    task automatic press(input logic [2:0] keys, input int len);
        PUSH = ~keys;
        repeat (len) tick();
        PUSH = 3'b111;
        repeat (DEB + 6) tick();
    endtask

    initial begin
        bit         ok, up, dn, lng, seen;
        logic [6:0] dq;
        int         len, r;

        repeat (3) tick();
        chk("rst_duty", 32'(DUTY), 0);
        chk("rst_req", 32'(UPD_REQ), 0);
        chk("rst_mode", 32'(MODE), 0);
        chk("rst_bcd", bcd_obs(), bcd_of(0));
        RST = 1'b0;
        repeat (5) tick();

        press(3'b001, 3);
        chk("short_duty", 32'(DUTY), 0);
        chk("short_req", 32'(UPD_REQ), 0);
        chk("short_bcd", bcd_obs(), bcd_of(0));

        PUSH = 3'b110;
        ok = 1'b0;
        dq = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (UPD_REQ && !ok) begin
                ok = 1'b1;
                dq = DUTY;
            end
        end
        PUSH = 3'b111;
        repeat (DEB + 6) tick();
        mdl_press(1, 0);
        chk("p1_req_seen", 32'(ok), 1);
        chk("p1_duty", 32'(dq), 5);
        chk("p1_bcd", bcd_obs(), bcd_of(mdl_t));
        chk("p1_req_held", 32'(UPD_REQ), 1);

        press(3'b001, 10);
        mdl_press(1, 0);
        chk("pend_duty", 32'(DUTY), 5);
        chk("pend_req", 32'(UPD_REQ), 1);
        chk("pend_bcd", bcd_obs(), bcd_of(mdl_t));
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("ack_req_low", 32'(UPD_REQ), 0);
        tick();
        chk("req2_req", 32'(UPD_REQ), 1);
        chk("req2_duty", 32'(DUTY), 10);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        ack_en = 1'b1;

        for (int n = 0; n < 30; n++) begin
            r   = $urandom_range(0, 5);
            up  = (r <= 2) || (r == 5);
            dn  = (r == 3) || (r == 4) || (r == 5);
            lng = ($urandom_range(0, 3) != 0);
            len = lng ? $urandom_range(6, 16) : $urandom_range(1, 3);
            press({1'b0, dn, up}, len);
            if (lng) mdl_press(up, dn);
            chk_state("rnd");
        end

        repeat (21) begin
            press(3'b001, 8);
            mdl_press(1, 0);
        end
        chk_state("sat_hi");
        repeat (21) begin
            press(3'b010, 8);
            mdl_press(0, 1);
        end
        chk_state("sat_lo");

        repeat (19) begin
            press(3'b001, 8);
            mdl_press(1, 0);
        end
        chk_state("pre_ramp");

        mdl_dir = (mdl_t == 100) ? -1 : 1;
        PUSH = 3'b011;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = MODE;
        end
        PUSH = 3'b111;
        chk("mode_on", 32'(ok), 1);

        for (int s = 0; s < 26; s++) begin
            repeat (RDIV - 1) tick();
            chk("ramp_hold_bcd", bcd_obs(), bcd_of(mdl_t));
            chk("ramp_hold_duty", 32'(DUTY), 32'(mdl_t));
            tick();
            mdl_ramp_step();
            chk("ramp_step_bcd", bcd_obs(), bcd_of(mdl_t));
        end

        PUSH = 3'b011;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = !MODE;
        end
        PUSH = 3'b111;
        chk("mode_off", 32'(ok), 1);
        repeat (30) tick();
        chk_state("frozen");
        chk("frozen_mode", 32'(MODE), 0);

        ack_en = 1'b0;
        press(3'b001, 10);
        chk("rr_pending", 32'(UPD_REQ), 1);
        RST = 1'b1;
        tick();
        chk("rr_req", 32'(UPD_REQ), 0);
        chk("rr_duty", 32'(DUTY), 0);
        chk("rr_mode", 32'(MODE), 0);
        chk("rr_bcd", bcd_obs(), bcd_of(0));
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (UPD_REQ || DUTY != 0) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
